// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control definitions: requester indices, geometry and
// address/data types used by the writeback arbiter.
package rf_ctrl_pkg;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MDU  = 2;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_starve_cnt.sv
// Saturating wait counter for one writeback requester; flags the requester as
// starved once it has been stalled STARVE_LIMIT consecutive cycles.
module rf_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  logic i_xfer,
    output logic o_starved
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
        end else if (!i_valid || i_xfer) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LIMIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign o_starved = (cnt_reg == LIMIT);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port among writeback sources and
// tracks registers with outstanding long-latency writes.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int DATA_W       = RF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic                      i_iss_valid,
    input  logic [ADDR_W-1:0]         i_iss_addr,
    output logic                      o_we,
    output logic [ADDR_W-1:0]         o_wa,
    output logic [DATA_W-1:0]         o_wd,
    output logic [RF_DEPTH-1:0]       o_pending
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    starved;
    logic [N_REQ-1:0]    xfer_vec;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                starve_hit;
    logic                xfer;
    logic [ADDR_W-1:0]   xfer_addr;
    logic [DATA_W-1:0]   xfer_data;

    logic                we_reg;
    logic [ADDR_W-1:0]   wa_reg;
    logic [DATA_W-1:0]   wd_reg;
    logic [RF_DEPTH-1:0] pending_reg;
    logic [RF_DEPTH-1:0] pending_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cnt
            rf_starve_cnt #(
                .STARVE_LIMIT(STARVE_LIMIT)
            ) u_cnt (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_valid  (i_req_valid[gi]),
                .i_xfer   (xfer_vec[gi]),
                .o_starved(starved[gi])
            );
        end
    endgenerate

    // Starved requesters preempt plain priority; lowest index wins within each tier.
    always_comb begin
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        starve_hit = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && starved[i]) begin
                starve_hit = 1'b1;
                gnt_idx    = IDX_W'(i);
            end
        end
        if (starve_hit) begin
            gnt_any = 1'b1;
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (i_req_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
    end

    assign xfer        = gnt_any && i_rst_n;
    assign o_req_ready = xfer ? (N_REQ'(1) << gnt_idx) : '0;
    assign xfer_vec    = i_req_valid & o_req_ready;
    assign xfer_addr   = i_req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign xfer_data   = i_req_data[gnt_idx*DATA_W +: DATA_W];

    // A newly issued writer outranks a retiring one on the same register.
    always_comb begin
        pending_next = pending_reg;
        if (xfer) begin
            pending_next[xfer_addr] = 1'b0;
        end
        if (i_iss_valid && (i_iss_addr != '0)) begin
            pending_next[i_iss_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            we_reg      <= 1'b0;
            wa_reg      <= '0;
            wd_reg      <= '0;
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            we_reg      <= xfer && (xfer_addr != '0);
            if (xfer) begin
                wa_reg <= xfer_addr;
                wd_reg <= xfer_data;
            end
        end
    end

    assign o_we      = we_reg;
    assign o_wa      = wa_reg;
    assign o_wd      = wd_reg;
    assign o_pending = pending_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: table vectors plus hand sequences
// for starvation promotion and reset, with a queue of expected write-port states.
module tb_rf_write_arbiter;

    localparam int N = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_addr = '0;
    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;
    logic [31:0]     pending;

    rf_write_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid),
        .i_req_addr (req_addr),
        .i_req_data (req_data),
        .o_req_ready(req_ready),
        .i_iss_valid(iss_valid),
        .i_iss_addr (iss_addr),
        .o_we       (we),
        .o_wa       (wa),
        .o_wd       (wd),
        .o_pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] data;
        logic            iss;
        logic [AW-1:0]   iss_a;
        logic [N-1:0]    exp_ready;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pend;
    } wr_t;

    vec_t        vecs[9];
    wr_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_pend = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                         input logic [N*DW-1:0] d, input logic iv, input logic [AW-1:0] ia);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        iss_valid = iv;
        iss_addr  = ia;
    endtask

    // Called just after a negedge with inputs driven; consumes one clock cycle.
    task automatic cycle(input string name, input logic [N-1:0] exp_ready);
        logic        xf;
        logic [4:0]  a;
        logic [31:0] d;
        wr_t         e;
        wr_t         got;
        #1;
        check({name, ".ready"}, 32'(req_ready), 32'(exp_ready));
        xf = 1'b0;
        a  = '0;
        d  = '0;
        for (int k = 0; k < N; k++) begin
            if (exp_ready[k] && req_valid[k]) begin
                xf = 1'b1;
                a  = req_addr[k*AW +: AW];
                d  = req_data[k*DW +: DW];
            end
        end
        if (xf) begin
            m_wa = a;
            m_wd = d;
            m_pend[a] = 1'b0;
        end
        if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        m_pend[0] = 1'b0;
        e.we = xf && (a != 0);
        e.wa = m_wa;
        e.wd = m_wd;
        e.pend = m_pend;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({name, ".we"}, 32'(we), 32'(got.we));
        check({name, ".wa"}, 32'(wa), 32'(got.wa));
        check({name, ".wd"}, wd, got.wd);
        check({name, ".pending"}, pending, got.pend);
        $display("[TB] %s: valid=%b ready=%b we=%b wa=%0d wd=0x%08h pending=0x%08h",
                 name, req_valid, req_ready, we, wa, wd, pending);
        @(negedge clk);
    endtask

    task automatic reset_cycle(input string name);
        rst_n = 1'b0;
        #1;
        check({name, ".ready_in_reset"}, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        m_wa = '0;
        m_wd = '0;
        m_pend = '0;
        check({name, ".we"}, 32'(we), 32'd0);
        check({name, ".wa"}, 32'(wa), 32'd0);
        check({name, ".wd"}, wd, 32'd0);
        check({name, ".pending"}, pending, 32'd0);
        $display("[TB] %s: reset cycle we=%b wa=%0d pending=0x%08h", name, we, wa, pending);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // addr/data packing: {req2, req1, req0}
        vecs[0] = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 5'd0, 3'b001};
        vecs[1] = '{3'b000, '0, '0, 1'b0, 5'd0, 3'b000};
        vecs[2] = '{3'b110, {5'd3, 5'd4, 5'd0}, {32'h33, 32'h44, 32'h0}, 1'b0, 5'd0, 3'b010};
        vecs[3] = '{3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFFFFFF, 32'h0, 32'h0}, 1'b0, 5'd0, 3'b100};
        vecs[4] = '{3'b111, {5'd1, 5'd2, 5'd6}, {32'hA1, 32'hA2, 32'hA6}, 1'b0, 5'd0, 3'b001};
        vecs[5] = '{3'b000, '0, '0, 1'b1, 5'd9, 3'b000};
        vecs[6] = '{3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 1'b0, 5'd0, 3'b100};
        vecs[7] = '{3'b010, {5'd0, 5'd12, 5'd0}, {32'h0, 32'h12, 32'h0}, 1'b1, 5'd12, 3'b010};
        vecs[8] = '{3'b010, {5'd0, 5'd12, 5'd0}, {32'h0, 32'h1212, 32'h0}, 1'b0, 5'd0, 3'b010};

        @(negedge clk);
        reset_cycle("reset");

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].iss, vecs[i].iss_a);
            cycle($sformatf("vec%0d", i), vecs[i].exp_ready);
        end
        drive('0, '0, '0, 1'b0, '0);
        cycle("idle", 3'b000);

        // Contention: LOAD stalls four cycles, then is promoted over ALU.
        for (int c = 0; c < 5; c++) begin
            drive(3'b011, {5'd0, 5'd7, 5'd3}, {32'h0, 32'h11, 32'(c + 100)}, 1'b0, '0);
            cycle($sformatf("contend%0d", c), (c < 4) ? 3'b001 : 3'b010);
        end
        drive(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'd200}, 1'b0, '0);
        cycle("contend_resume", 3'b001);
        drive('0, '0, '0, 1'b0, '0);
        cycle("idle2", 3'b000);

        // Reset with LOAD counter at 3 and a pending bit set.
        drive('0, '0, '0, 1'b1, 5'd20);
        cycle("iss20", 3'b000);
        for (int c = 0; c < 3; c++) begin
            drive(3'b011, {5'd0, 5'd8, 5'd2}, {32'h0, 32'h88, 32'h22}, 1'b0, '0);
            cycle($sformatf("prerst%0d", c), 3'b001);
        end
        reset_cycle("midreset");
        for (int c = 0; c < 5; c++) begin
            drive(3'b011, {5'd0, 5'd8, 5'd2}, {32'h0, 32'h88, 32'h22}, 1'b0, '0);
            cycle($sformatf("postrst%0d", c), (c < 4) ? 3'b001 : 3'b010);
        end
        drive('0, '0, '0, 1'b0, '0);
        cycle("idle3", 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
